// File: rtl/cdb_writeback_arbiter_pkg.sv
// Shared types and sizing for the execute->writeback CDB arbiter.
package cdb_writeback_arbiter_pkg;

    localparam int unsigned NUM_FU     = 3;   // 0=ALU, 1=BRU, 2=LSU
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned PHY_WIDTH  = 6;
    localparam int unsigned ROB_WIDTH  = 5;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned SRC_WIDTH  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic [ROB_WIDTH-1:0]  rob_idx;
        logic [PHY_WIDTH-1:0]  phy_rd;
        logic                  rd_we;
        logic [DATA_WIDTH-1:0] data;
    } cdb_packet_t;

endpackage

// File: rtl/cdb_writeback_arbiter_if.sv
// FU result handshake plus CDB broadcast bundle; slave side is the arbiter.
interface cdb_writeback_arbiter_if;
    import cdb_writeback_arbiter_pkg::*;

    logic [NUM_FU-1:0]       fu_valid;
    logic [NUM_FU-1:0]       fu_ready;
    cdb_packet_t [NUM_FU-1:0] fu_result;
    logic                    cdb_valid;
    cdb_packet_t             cdb_packet;
    logic [SRC_WIDTH-1:0]    cdb_src;

    modport master (
        output fu_valid,
        output fu_result,
        input  fu_ready,
        input  cdb_valid,
        input  cdb_packet,
        input  cdb_src
    );

    modport slave (
        input  fu_valid,
        input  fu_result,
        output fu_ready,
        output cdb_valid,
        output cdb_packet,
        output cdb_src
    );

endinterface

// File: rtl/cdb_writeback_arbiter_wb_fifo.sv
// Per-FU result buffer; ready is registered from next-cycle occupancy so a pop never reaches it combinationally.
module wb_fifo
    import cdb_writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  cdb_packet_t din,
    output cdb_packet_t head_c,
    output logic        empty_c,
    output logic        ready
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic             full_c, full_nxt_c;
    logic             do_push, do_pop;
    cdb_packet_t      mem [DEPTH];

    assign full_c  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign empty_c = (wr_ptr == rd_ptr);
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;

    // Flush empties the buffer and overrides any same-cycle push or pop
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (do_push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
        end
    end

    assign full_nxt_c = (wr_ptr_nxt[PTR_W-1] != rd_ptr_nxt[PTR_W-1]) &&
                        (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ready  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            ready  <= !full_nxt_c;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[ADDR_W-1:0]] <= din;
    end

    assign head_c = mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// Buffers FU results and round-robin broadcasts one per cycle on the CDB.
// Optional CDB_PERF_EN adds per-FU saturating stall counters (perf_stall_cnt).
module cdb_writeback_arbiter
    import cdb_writeback_arbiter_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    cdb_writeback_arbiter_if.slave     wb
`ifdef CDB_PERF_EN
    ,
    output logic [NUM_FU-1:0][31:0]    perf_stall_cnt
`endif
);

    logic [NUM_FU-1:0]        empty_c;
    logic [NUM_FU-1:0]        ready;
    logic [NUM_FU-1:0]        pop_c;
    cdb_packet_t [NUM_FU-1:0] head_c;

    logic                 gnt_valid_c;
    logic [SRC_WIDTH-1:0] gnt_idx_c;
    logic [SRC_WIDTH-1:0] cand_c;
    logic [SRC_WIDTH-1:0] rr_ptr;

    logic                 cdb_valid_q;
    cdb_packet_t          cdb_packet_q;
    logic [SRC_WIDTH-1:0] cdb_src_q;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
        wb_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .push    (wb.fu_valid[i] && ready[i]),
            .pop     (pop_c[i]),
            .din     (wb.fu_result[i]),
            .head_c  (head_c[i]),
            .empty_c (empty_c[i]),
            .ready   (ready[i])
        );
    end

    // Round-robin search starting one past the last granted FU
    always_comb begin
        gnt_valid_c = 1'b0;
        gnt_idx_c   = rr_ptr;
        cand_c      = rr_ptr;
        for (int unsigned off = 1; off <= NUM_FU; off++) begin
            cand_c = SRC_WIDTH'((32'(rr_ptr) + off) % NUM_FU);
            if (!gnt_valid_c && !empty_c[cand_c]) begin
                gnt_valid_c = 1'b1;
                gnt_idx_c   = cand_c;
            end
        end
        if (flush) gnt_valid_c = 1'b0;
    end

    always_comb begin
        pop_c = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            pop_c[i] = gnt_valid_c && (gnt_idx_c == SRC_WIDTH'(i));
        end
    end

    // CDB output register; packet and source hold their last value when idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid_q  <= 1'b0;
            cdb_packet_q <= '0;
            cdb_src_q    <= '0;
            rr_ptr       <= SRC_WIDTH'(NUM_FU - 1);
        end else begin
            cdb_valid_q <= gnt_valid_c;
            if (gnt_valid_c) begin
                cdb_packet_q <= head_c[gnt_idx_c];
                cdb_src_q    <= gnt_idx_c;
                rr_ptr       <= gnt_idx_c;
            end
        end
    end

    assign wb.fu_ready   = ready;
    assign wb.cdb_valid  = cdb_valid_q;
    assign wb.cdb_packet = cdb_packet_q;
    assign wb.cdb_src    = cdb_src_q;

`ifdef CDB_PERF_EN
    // Stall = FU offering a result the buffer cannot take; unaffected by flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (wb.fu_valid[i] && !ready[i] && (perf_stall_cnt[i] != 32'hFFFF_FFFF)) begin
                    perf_stall_cnt[i] <= perf_stall_cnt[i] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Directed bench for cdb_writeback_arbiter: reset, round-robin contention, back-pressure,
// single result, rd_we=0 broadcast, flush and asynchronous reset.
module tb_cdb_writeback_arbiter;
    import cdb_writeback_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    cdb_writeback_arbiter_if ifc ();

`ifdef CDB_PERF_EN
    logic [NUM_FU-1:0][31:0] perf;
`endif

    cdb_writeback_arbiter u_dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush)
        ,
        .wb    (ifc)
`ifdef CDB_PERF_EN
        ,
        .perf_stall_cnt (perf)
`endif
    );

    int checks   = 0;
    int failures = 0;

    cdb_packet_t          pend [NUM_FU][$];
    cdb_packet_t          log_pkt [$];
    logic [SRC_WIDTH-1:0] log_src [$];
    int                   stall_cnt [NUM_FU];

    function automatic cdb_packet_t mk(input int rob, input int phy, input logic we, input logic [31:0] d);
        cdb_packet_t p;
        p.rob_idx = ROB_WIDTH'(rob);
        p.phy_rd  = PHY_WIDTH'(phy);
        p.rd_we   = we;
        p.data    = d;
        return p;
    endfunction

    function automatic cdb_packet_t item(input int rob);
        return mk(rob, rob + 1, 1'b1, 32'hC0DE_0000 + 32'(rob));
    endfunction

    // One clock: offer pending FU results, note accepts/stalls, record any broadcast
    task automatic tick();
        logic [NUM_FU-1:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (pend[i].size() != 0) begin
                ifc.fu_valid[i]  = 1'b1;
                ifc.fu_result[i] = pend[i][0];
            end else begin
                ifc.fu_valid[i]  = 1'b0;
                ifc.fu_result[i] = '0;
            end
        end
        #1;
        for (int i = 0; i < NUM_FU; i++) begin
            if (ifc.fu_valid[i] && ifc.fu_ready[i]) acc[i] = 1'b1;
            if (ifc.fu_valid[i] && !ifc.fu_ready[i]) stall_cnt[i]++;
        end
        @(posedge clk);
        for (int i = 0; i < NUM_FU; i++) begin
            if (acc[i]) void'(pend[i].pop_front());
        end
        @(negedge clk);
        if (ifc.cdb_valid) begin
            log_pkt.push_back(ifc.cdb_packet);
            log_src.push_back(ifc.cdb_src);
        end
    endtask

    task automatic test_reset();
        pend[0].push_back(item(1));
        pend[1].push_back(item(2));
        pend[2].push_back(item(3));
        ifc.fu_valid = '1;
        for (int i = 0; i < NUM_FU; i++) ifc.fu_result[i] = pend[i][0];
        repeat (3) @(negedge clk);
        checks++;
        if (ifc.cdb_valid !== 1'b0) begin failures++; $display("FAIL reset_cdb_valid got=%0b exp=0", ifc.cdb_valid); end
        checks++;
        if (ifc.fu_ready !== 3'b000) begin failures++; $display("FAIL reset_fu_ready got=%b exp=000", ifc.fu_ready); end
        checks++;
        if (ifc.cdb_src !== '0) begin failures++; $display("FAIL reset_cdb_src got=%0d exp=0", ifc.cdb_src); end
        checks++;
        if (ifc.cdb_packet !== '0) begin failures++; $display("FAIL reset_cdb_packet got=%h exp=0", ifc.cdb_packet); end
        rst = 1'b1;
        tick();
        checks++;
        if (ifc.fu_ready !== 3'b111) begin failures++; $display("FAIL release_fu_ready got=%b exp=111", ifc.fu_ready); end
        checks++;
        if (ifc.cdb_valid !== 1'b0) begin failures++; $display("FAIL release_cdb_valid got=%0b exp=0", ifc.cdb_valid); end
        tick();
        checks++;
        if (ifc.cdb_valid !== 1'b0) begin failures++; $display("FAIL no_bypass_cdb_valid got=%0b exp=0", ifc.cdb_valid); end
        tick();
        checks++;
        if (ifc.cdb_valid !== 1'b1 || ifc.cdb_src !== 2'd0 || ifc.cdb_packet !== item(1)) begin
            failures++;
            $display("FAIL first_broadcast got v=%0b src=%0d pkt=%h exp v=1 src=0 pkt=%h",
                     ifc.cdb_valid, ifc.cdb_src, ifc.cdb_packet, item(1));
        end
        repeat (3) tick();
    endtask

    task automatic test_contention();
        log_pkt.delete(); log_src.delete();
        for (int k = 0; k < 4; k++) begin
            pend[0].push_back(item(8 + k));
            pend[1].push_back(item(12 + k));
            pend[2].push_back(item(16 + k));
        end
        repeat (16) tick();
        checks++;
        if (log_pkt.size() != 12) begin failures++; $display("FAIL contention_count got=%0d exp=12", log_pkt.size()); end
        for (int k = 0; k < 12; k++) begin
            int exp_rob;
            exp_rob = (k % 3 == 0) ? 8 + k / 3 : (k % 3 == 1) ? 12 + k / 3 : 16 + k / 3;
            checks++;
            if (k >= log_pkt.size()) begin
                failures++; $display("FAIL contention_entry%0d got=none exp src=%0d rob=%0d", k, k % 3, exp_rob);
            end else if (log_src[k] !== SRC_WIDTH'(k % 3) || log_pkt[k] !== item(exp_rob)) begin
                failures++;
                $display("FAIL contention_entry%0d got src=%0d rob=%0d pkt=%h exp src=%0d rob=%0d",
                         k, log_src[k], log_pkt[k].rob_idx, log_pkt[k], k % 3, exp_rob);
            end
        end
    endtask

    task automatic test_back_to_back();
        log_pkt.delete(); log_src.delete();
        for (int k = 0; k < 6; k++) begin
            pend[0].push_back(item(20 + k));
            pend[1].push_back(item(26 + k));
            pend[2].push_back(item(k));
        end
        for (int t = 1; t <= 22; t++) begin
            tick();
            if (t == 1) begin
                checks++;
                if (ifc.fu_ready !== 3'b111) begin failures++; $display("FAIL b2b_ready_t1 got=%b exp=111", ifc.fu_ready); end
            end
            if (t == 2) begin
                checks++;
                if (ifc.fu_ready !== 3'b001) begin failures++; $display("FAIL b2b_ready_t2 got=%b exp=001", ifc.fu_ready); end
            end
        end
        checks++;
        if (log_pkt.size() != 18) begin failures++; $display("FAIL b2b_count got=%0d exp=18", log_pkt.size()); end
        for (int k = 0; k < 18; k++) begin
            int exp_rob;
            exp_rob = (k % 3 == 0) ? 20 + k / 3 : (k % 3 == 1) ? 26 + k / 3 : k / 3;
            checks++;
            if (k >= log_pkt.size()) begin
                failures++; $display("FAIL b2b_entry%0d got=none exp src=%0d rob=%0d", k, k % 3, exp_rob);
            end else if (log_src[k] !== SRC_WIDTH'(k % 3) || log_pkt[k] !== item(exp_rob)) begin
                failures++;
                $display("FAIL b2b_entry%0d got src=%0d rob=%0d pkt=%h exp src=%0d rob=%0d",
                         k, log_src[k], log_pkt[k].rob_idx, log_pkt[k], k % 3, exp_rob);
            end
        end
`ifdef CDB_PERF_EN
        checks++;
        if (perf[2] !== 32'(stall_cnt[2])) begin
            failures++; $display("FAIL perf_stall_lsu got=%0d exp=%0d", perf[2], stall_cnt[2]);
        end
`endif
    endtask

    task automatic test_single_fu();
        cdb_packet_t exp_p;
        exp_p = mk(3, 10, 1'b1, 32'h0000_1234);
        pend[0].push_back(exp_p);
        tick();
        checks++;
        if (ifc.cdb_valid !== 1'b0) begin failures++; $display("FAIL single_accept_cycle got=%0b exp=0", ifc.cdb_valid); end
        tick();
        checks++;
        if (ifc.cdb_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", ifc.cdb_valid); end
        checks++;
        if (ifc.cdb_src !== 2'd0) begin failures++; $display("FAIL single_src got=%0d exp=0", ifc.cdb_src); end
        checks++;
        if (ifc.cdb_packet !== exp_p) begin failures++; $display("FAIL single_packet got=%h exp=%h", ifc.cdb_packet, exp_p); end
        tick();
        checks++;
        if (ifc.cdb_valid !== 1'b0) begin failures++; $display("FAIL single_idle got=%0b exp=0", ifc.cdb_valid); end
    endtask

    task automatic test_store();
        pend[2].push_back(mk(7, 0, 1'b0, 32'hDEAD_BEEF));
        tick();
        checks++;
        if (ifc.cdb_valid !== 1'b0) begin failures++; $display("FAIL store_accept_cycle got=%0b exp=0", ifc.cdb_valid); end
        tick();
        checks++;
        if (ifc.cdb_valid !== 1'b1 || ifc.cdb_src !== 2'd2) begin
            failures++; $display("FAIL store_broadcast got v=%0b src=%0d exp v=1 src=2", ifc.cdb_valid, ifc.cdb_src);
        end
        checks++;
        if (ifc.cdb_packet.rob_idx !== 5'd7 || ifc.cdb_packet.rd_we !== 1'b0) begin
            failures++; $display("FAIL store_fields got rob=%0d we=%0b exp rob=7 we=0",
                                 ifc.cdb_packet.rob_idx, ifc.cdb_packet.rd_we);
        end
        tick();
    endtask

    task automatic test_flush();
        log_pkt.delete(); log_src.delete();
        for (int k = 0; k < 3; k++) begin
            pend[0].push_back(item(20 + k));
            pend[1].push_back(item(23 + k));
            pend[2].push_back(item(26 + k));
        end
        repeat (3) tick();
        checks++;
        if (log_pkt.size() != 2) begin
            failures++; $display("FAIL preflush_count got=%0d exp=2", log_pkt.size());
        end else if (log_pkt[0] !== item(20) || log_pkt[1] !== item(23)) begin
            failures++; $display("FAIL preflush_entries got=%0d,%0d exp=20,23", log_pkt[0].rob_idx, log_pkt[1].rob_idx);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (ifc.cdb_valid !== 1'b0) begin failures++; $display("FAIL flush_cdb_valid got=%0b exp=0", ifc.cdb_valid); end
        checks++;
        if (ifc.fu_ready !== 3'b111) begin failures++; $display("FAIL flush_fu_ready got=%b exp=111", ifc.fu_ready); end
        log_pkt.delete(); log_src.delete();
        repeat (4) tick();
        checks++;
        if (log_pkt.size() != 1) begin
            failures++; $display("FAIL postflush_count got=%0d exp=1", log_pkt.size());
        end else if (log_pkt[0] !== item(28) || log_src[0] !== 2'd2) begin
            failures++; $display("FAIL postflush_entry got rob=%0d src=%0d exp rob=28 src=2",
                                 log_pkt[0].rob_idx, log_src[0]);
        end
    endtask

    task automatic test_async_reset();
        pend[0].push_back(item(1));
        pend[1].push_back(item(2));
        repeat (2) tick();
        checks++;
        if (ifc.cdb_valid !== 1'b1 || ifc.cdb_packet !== item(1)) begin
            failures++; $display("FAIL areset_pre got v=%0b pkt=%h exp v=1 pkt=%h", ifc.cdb_valid, ifc.cdb_packet, item(1));
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ifc.cdb_valid !== 1'b0 || ifc.cdb_packet !== '0) begin
            failures++; $display("FAIL areset_cdb got v=%0b pkt=%h exp v=0 pkt=0", ifc.cdb_valid, ifc.cdb_packet);
        end
        checks++;
        if (ifc.fu_ready !== 3'b000) begin failures++; $display("FAIL areset_fu_ready got=%b exp=000", ifc.fu_ready); end
        for (int i = 0; i < NUM_FU; i++) begin
            pend[i].delete();
            stall_cnt[i] = 0;
        end
        @(negedge clk);
        rst = 1'b1;
        log_pkt.delete(); log_src.delete();
        repeat (4) tick();
        checks++;
        if (log_pkt.size() != 0) begin failures++; $display("FAIL areset_dropped got=%0d broadcasts exp=0", log_pkt.size()); end
        checks++;
        if (ifc.fu_ready !== 3'b111) begin failures++; $display("FAIL areset_release_ready got=%b exp=111", ifc.fu_ready); end
    endtask

    initial begin
        rst           = 1'b0;
        flush         = 1'b0;
        ifc.fu_valid  = '0;
        ifc.fu_result = '0;
        for (int i = 0; i < NUM_FU; i++) stall_cnt[i] = 0;
        test_reset();
        test_contention();
        test_back_to_back();
        test_single_fu();
        test_store();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
